// File: rtl/readout_pkg.sv
// Shared types and constants for the measurement readout frame generator.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DATA,
        CHK
    } state_t;

    localparam int unsigned FRAME_BYTES = 15;
    localparam int unsigned DATA_BYTES  = 12;
    localparam logic [7:0]  CRC8_POLY   = 8'h07;

endpackage

// File: rtl/crc8_byte_step.sv
// Combinational CRC-8 update over one byte, MSB first, no reflection.
module crc8_byte_step
    import readout_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC8_POLY) : (crc_out << 1);
        end
    end

endmodule

// File: rtl/measurement_readout.sv
// Snapshots TIME_HIGH/TIME_LOW/PERIOD on START and streams a 15-byte frame over valid/ready.
// Define READOUT_CRC8_EN to send a CRC-8 instead of the XOR checksum in the CHK byte.
module measurement_readout
    import readout_pkg::*;
#(
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [COUNT_WIDTH-1:0] TIME_HIGH,
    input  logic [COUNT_WIDTH-1:0] TIME_LOW,
    input  logic [COUNT_WIDTH-1:0] PERIOD,
    input  logic                   START,
    input  logic                   CLR_OVERRUN,
    output logic [7:0]             BYTE_OUT,
    output logic                   BYTE_VALID,
    input  logic                   BYTE_READY,
    output logic                   BUSY,
    output logic                   OVERRUN
);

    localparam int unsigned SNAP_W   = 3 * COUNT_WIDTH;
    localparam logic [3:0]  LAST_IDX = 4'(DATA_BYTES - 1);

    state_t            state_q;
    logic [3:0]        idx_q;
    logic [SNAP_W-1:0] snap_q;
    logic [7:0]        seq_q;
    logic [7:0]        chk_q;
    logic [7:0]        chk_next;
    logic [7:0]        snap_top;
    logic              xfer;

    assign xfer     = BYTE_VALID & BYTE_READY;
    assign snap_top = snap_q[SNAP_W-1 -: 8];

    // BYTE_OUT always holds the byte being offered, so it is the checksum input on transfer.
`ifdef READOUT_CRC8_EN
    crc8_byte_step u_crc8_byte_step (
        .crc_in  (chk_q),
        .byte_in (BYTE_OUT),
        .crc_out (chk_next)
    );
`else
    always_comb begin
        chk_next = chk_q ^ BYTE_OUT;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            seq_q      <= '0;
            chk_q      <= '0;
            BYTE_OUT   <= '0;
            BYTE_VALID <= 1'b0;
            BUSY       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            if (START && BUSY) begin
                OVERRUN <= 1'b1;
            end else if (CLR_OVERRUN) begin
                OVERRUN <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q    <= HDR;
                        snap_q     <= {PERIOD, TIME_HIGH, TIME_LOW};
                        chk_q      <= '0;
                        BYTE_OUT   <= HEADER_BYTE;
                        BYTE_VALID <= 1'b1;
                        BUSY       <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state_q  <= SEQ;
                        BYTE_OUT <= seq_q;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        state_q  <= DATA;
                        idx_q    <= '0;
                        chk_q    <= chk_next;
                        BYTE_OUT <= snap_top;
                        snap_q   <= snap_q << 8;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk_q <= chk_next;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= CHK;
                            BYTE_OUT <= chk_next;
                        end else begin
                            idx_q    <= idx_q + 4'd1;
                            BYTE_OUT <= snap_top;
                            snap_q   <= snap_q << 8;
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        state_q    <= IDLE;
                        BYTE_OUT   <= '0;
                        BYTE_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                        seq_q      <= seq_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
